// File: rtl/r6_sum_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r6_sum_ctrl_pkg
// Description : Shared state encoding and default constants for the R6 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package r6_sum_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int c_PIPE_LAT = 5;
    localparam int c_KSIZE    = 13;
    localparam int c_CNT_W    = 10;

endpackage
`default_nettype wire

// File: rtl/r6_valid_delay.sv
`default_nettype none
// ============================================================================
// Module      : r6_valid_delay
// Description : Fixed-depth shift register of {valid, data} with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module r6_valid_delay #(
    parameter int DEPTH  = 5,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              any_valid
);

    logic [DEPTH-1:0]  r_vld;
    logic [DATA_W-1:0] r_dat [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= valid_in;
            r_dat[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign valid_out = r_vld[DEPTH-1];
    assign data_out  = r_dat[DEPTH-1];
    assign any_valid = |r_vld;

endmodule
`default_nettype wire

// File: rtl/r6_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : r6_sum_ctrl
// Description : Frame sequencer generating pipeline-aligned enables for the R6
//               13-tap column-sum / sliding-window accumulator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module r6_sum_ctrl
    import r6_sum_ctrl_pkg::*;
#(
    parameter int COLS     = 11,
    parameter int ROWS     = 11,
    parameter int KSIZE    = c_KSIZE,
    parameter int PIPE_LAT = c_PIPE_LAT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                valid_i,
    output logic                ld_en,
    output logic                sum_en,
    output logic                cum_en,
    output logic                count_en,
    output logic                start_en,
    output logic                valid_o,
    output logic [c_CNT_W-1:0]  col_o,
    output logic [c_CNT_W-1:0]  row_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int                c_DW       = 1 + 2 * c_CNT_W;
    localparam logic [c_CNT_W-1:0] c_COL_LAST = c_CNT_W'(COLS - 1);
    localparam logic [c_CNT_W-1:0] c_ROW_LAST = c_CNT_W'(ROWS - 1);
    localparam logic [c_CNT_W-1:0] c_K_CUM    = c_CNT_W'(KSIZE);
    localparam logic [c_CNT_W-1:0] c_K_WIN    = c_CNT_W'(KSIZE - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_in_col;
    logic [c_CNT_W-1:0] r_in_row;
    logic               r_sup;
    logic               r_err;
    logic               r_done;
    logic               r_valid_o;
    logic [c_CNT_W-1:0] r_col_o;
    logic [c_CNT_W-1:0] r_row_o;

    logic               w_accept;
    logic               w_gap;
    logic               w_ign;
    logic               w_start;
    logic               w_done;
    logic               w_bad_in;
    logic               w_d_valid;
    logic               w_d_any;
    logic [c_DW-1:0]    w_d_data;
    logic               w_d_bad;
    logic [c_CNT_W-1:0] w_d_row;
    logic [c_CNT_W-1:0] w_d_col;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_gap       = 1'b0;
        w_ign       = 1'b0;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RUN;
                end else if (valid_i) begin
                    w_ign = 1'b1;
                end
            end
            ST_RUN: begin
                if (valid_i) begin
                    w_accept = 1'b1;
                    if (r_in_col == c_COL_LAST && r_in_row == c_ROW_LAST)
                        w_state_nxt = ST_DRAIN;
                end else if (r_in_col != '0) begin
                    w_gap = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_ign = valid_i;
                // Pipeline empty now; the accumulator register emits its last window this cycle.
                if (!w_d_any) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_col <= '0;
            r_in_row <= '0;
            r_sup    <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_start) begin
                r_in_col <= '0;
                r_in_row <= '0;
                r_sup    <= 1'b0;
                r_err    <= 1'b0;
            end
            if (w_accept) begin
                if (r_in_col == '0) r_sup <= 1'b0;
                if (r_in_col == c_COL_LAST) begin
                    r_in_col <= '0;
                    if (r_in_row != c_ROW_LAST) r_in_row <= r_in_row + 1'b1;
                end else begin
                    r_in_col <= r_in_col + 1'b1;
                end
            end
            if (w_gap) begin
                r_err <= 1'b1;
                r_sup <= 1'b1;
            end
            if (w_ign) r_err <= 1'b1;
        end
    end

    // Windows after a mid-row gap would mix stale subtract-line data; tag them.
    assign w_bad_in = r_sup & (r_in_col != '0);

    r6_valid_delay #(
        .DEPTH  (PIPE_LAT),
        .DATA_W (c_DW)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_start),
        .valid_in  (w_accept),
        .data_in   ({w_bad_in, r_in_row, r_in_col}),
        .valid_out (w_d_valid),
        .data_out  (w_d_data),
        .any_valid (w_d_any)
    );

    assign {w_d_bad, w_d_row, w_d_col} = w_d_data;

    assign sum_en   = w_d_valid;
    assign count_en = w_d_valid;
    assign ld_en    = w_d_valid & (w_d_col == '0);
    assign start_en = ld_en;
    assign cum_en   = w_d_valid & (w_d_col >= c_K_CUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_o <= 1'b0;
            r_col_o   <= '0;
            r_row_o   <= '0;
        end else begin
            r_valid_o <= w_d_valid & (w_d_col >= c_K_WIN) & ~w_d_bad;
            r_col_o   <= (w_d_valid & (w_d_col >= c_K_WIN) & ~w_d_bad) ? w_d_col : '0;
            if (w_start)        r_row_o <= '0;
            else if (w_d_valid) r_row_o <= w_d_row;
        end
    end

    assign valid_o = r_valid_o;
    assign col_o   = r_col_o;
    assign row_o   = r_row_o;
    assign busy_o  = (r_state != ST_IDLE);
    assign done_o  = r_done;
    assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_r6_sum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_r6_sum_ctrl
// Description : Randomized self-checking bench with an event-scheduling model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r6_sum_ctrl;

    localparam int COLS     = 20;
    localparam int ROWS     = 4;
    localparam int KSIZE    = 13;
    localparam int PIPE_LAT = 5;
    localparam int N        = 8192;

    logic       clk = 1'b0;
    logic       rst, start_i, valid_i;
    logic       ld_en, sum_en, cum_en, count_en, start_en, valid_o;
    logic [9:0] col_o, row_o;
    logic       busy_o, done_o, err_o;

    r6_sum_ctrl #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .KSIZE    (KSIZE),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .valid_i  (valid_i),
        .ld_en    (ld_en),
        .sum_en   (sum_en),
        .cum_en   (cum_en),
        .count_en (count_en),
        .start_en (start_en),
        .valid_o  (valid_o),
        .col_o    (col_o),
        .row_o    (row_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    // Expected output per cycle, filled ahead of time as columns are accepted.
    bit exp_ld[N], exp_sum[N], exp_cum[N], exp_vo[N];
    bit exp_done[N], exp_busy[N], exp_err[N], exp_rowset[N];
    int exp_col[N], exp_rowval[N];

    int cyc, n_vec, n_bad;
    int m_col, m_row, m_done_at, row_hold;
    bit m_busy, m_err, m_spoil;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic schedule(input int c, input int k, input int r, input bit spoiled);
        int e;
        e = c + PIPE_LAT;
        exp_sum[e] = 1'b1;
        exp_ld[e]  = (k == 0);
        exp_cum[e] = (k >= KSIZE);
        if (k >= KSIZE - 1 && !spoiled) begin
            exp_vo[e+1]  = 1'b1;
            exp_col[e+1] = k;
        end
        exp_rowset[e+1] = 1'b1;
        exp_rowval[e+1] = r;
    endtask

    task automatic model_step(input bit r, input bit s, input bit v);
        int n;
        n = cyc;
        if (r) begin
            for (int i = n + 1; i <= n + 10; i++) begin
                exp_ld[i] = 0; exp_sum[i] = 0; exp_cum[i] = 0; exp_vo[i] = 0;
                exp_done[i] = 0; exp_col[i] = 0; exp_rowset[i] = 0; exp_rowval[i] = 0;
            end
            m_busy = 0; m_done_at = -1; m_err = 0;
            m_col = 0; m_row = 0; m_spoil = 0;
            exp_rowset[n+1] = 1'b1;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1; m_err = 0; m_col = 0; m_row = 0; m_spoil = 0;
                exp_rowset[n+1] = 1'b1;
                exp_rowval[n+1] = 0;
            end else if (v) begin
                m_err = 1;
            end
        end else if (m_done_at < 0) begin
            if (v) begin
                schedule(n, m_col, m_row, m_spoil && m_col != 0);
                if (m_col == 0) m_spoil = 0;
                if (m_col == COLS - 1) begin
                    m_col = 0;
                    if (m_row == ROWS - 1) m_done_at = n + PIPE_LAT + 2;
                    else m_row++;
                end else begin
                    m_col++;
                end
            end else if (m_col != 0) begin
                m_err = 1;
                m_spoil = 1;
            end
        end else begin
            if (v) m_err = 1;
            if (n + 1 == m_done_at) begin
                m_busy = 0;
                m_done_at = -1;
                exp_done[n+1] = 1'b1;
            end
        end
        exp_busy[n+1] = m_busy;
        exp_err[n+1]  = m_err;
    endtask

    task automatic check_cycle();
        if (exp_rowset[cyc]) row_hold = exp_rowval[cyc];
        chk("ld_en",    {31'd0, ld_en},    {31'd0, exp_ld[cyc]});
        chk("sum_en",   {31'd0, sum_en},   {31'd0, exp_sum[cyc]});
        chk("count_en", {31'd0, count_en}, {31'd0, exp_sum[cyc]});
        chk("start_en", {31'd0, start_en}, {31'd0, exp_ld[cyc]});
        chk("cum_en",   {31'd0, cum_en},   {31'd0, exp_cum[cyc]});
        chk("valid_o",  {31'd0, valid_o},  {31'd0, exp_vo[cyc]});
        chk("col_o",    {22'd0, col_o},    exp_col[cyc]);
        chk("row_o",    {22'd0, row_o},    row_hold);
        chk("busy_o",   {31'd0, busy_o},   {31'd0, exp_busy[cyc]});
        chk("done_o",   {31'd0, done_o},   {31'd0, exp_done[cyc]});
        chk("err_o",    {31'd0, err_o},    {31'd0, exp_err[cyc]});
    endtask

    task automatic tick(input bit r, input bit s, input bit v);
        rst = r; start_i = s; valid_i = v;
        model_step(r, s, v);
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic run_frame(input int gap_max, input bit drop, input bit noise);
        int drop_row, drop_col;
        drop_row = drop ? int'($urandom_range(0, ROWS - 1)) : -1;
        drop_col = int'($urandom_range(1, COLS - 1));
        tick(0, 1, 0);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r == drop_row && c == drop_col)
                    repeat ($urandom_range(1, 3)) tick(0, 0, 0);
                tick(0, noise && ($urandom_range(0, 9) == 0), 1);
            end
            if (r != ROWS - 1) repeat ($urandom_range(0, gap_max)) tick(0, 0, 0);
        end
        for (int k = 0; k < 12; k++) tick(0, 0, noise && ($urandom_range(0, 4) == 0));
    endtask

    initial begin
        cyc = 0; n_vec = 0; n_bad = 0; row_hold = 0;
        m_col = 0; m_row = 0; m_done_at = -1; m_busy = 0; m_err = 0; m_spoil = 0;
        rst = 1'b1; start_i = 1'b0; valid_i = 1'b0;

        tick(1, 0, 0);
        tick(1, 0, 0);
        repeat (3) tick(0, 0, 0);
        tick(0, 0, 1);
        repeat (3) tick(0, 0, 0);

        run_frame(0, 0, 0);
        run_frame(10, 0, 0);
        run_frame(3, 1, 0);

        tick(0, 1, 0);
        repeat (8) tick(0, 0, 1);
        tick(1, 0, 1);
        repeat (12) tick(0, 0, 0);

        for (int f = 0; f < 6; f++)
            run_frame(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
